// File: rtl/spiflash_pkg.sv
// Shared constants, state encoding and helpers for the SPI flash read controller.
package spiflash_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RPD  = 8'hAB;

  typedef enum logic [2:0] {
    WAKE_CMD,
    WAKE_WAIT,
    IDLE,
    SHIFT,
    RESP
  } state_e;

  // Flash delivers byte0 first (MSB-first); the bus wants byte0 in the low lane.
  function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_shifter.sv
// Mode-0 SPI bit engine: DIV-divided SCK, 64-bit shift register, start/done handshake.
module spi_shifter
  import spiflash_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [63:0]       load_data,
  input  logic [6:0]        nbits,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  output logic [DATA_W-1:0] rx_data
);

  logic        active_q, active_d;
  logic        fin_q, fin_d;
  logic        done_q, done_d;
  logic        sck_q, sck_d;
  logic [63:0] sr_q, sr_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic [6:0]  len_q, len_d;
  logic        last_bit;

  always_comb begin
    // NOTE: every _d takes its current value first so no branch can infer a latch.
    active_d = active_q;
    fin_d    = 1'b0;
    done_d   = fin_q;
    sck_d    = sck_q;
    sr_d     = sr_q;
    div_d    = div_q;
    bit_d    = bit_q;
    len_d    = len_q;
    last_bit = ({1'b0, bit_q} == (len_q - 7'd1));

    if (start && !active_q) begin
      active_d = 1'b1;
      sr_d     = load_data;
      len_d    = nbits;
      div_d    = '0;
      bit_d    = '0;
      sck_d    = 1'b0;
    end else if (active_q) begin
      if (div_q == 8'(DIV - 1)) begin
        div_d = '0;
        if (!sck_q) begin
          sck_d    = 1'b1;
          sr_d[0]  = miso;
        end else begin
          sck_d = 1'b0;
          sr_d  = {sr_q[62:0], 1'b0};
          bit_d = bit_q + 6'd1;
          if (last_bit) begin
            active_d = 1'b0;
            fin_d    = 1'b1;
          end
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      fin_q    <= 1'b0;
      done_q   <= 1'b0;
      sck_q    <= 1'b0;
      sr_q     <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      len_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      active_q <= active_d;
      fin_q    <= fin_d;
      done_q   <= done_d;
      sck_q    <= sck_d;
      sr_q     <= sr_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      len_q    <= len_d;
    end
  end

  // The fin stage keeps busy high one extra clk so the FSM sees done two clk after the last fall.
  assign busy    = active_q | fin_q;
  assign done    = done_q;
  assign sck     = sck_q;
  assign mosi    = active_q & sr_q[63];
  assign rx_data = sr_q[32:1];

endmodule

// File: rtl/spiflash_reader.sv
// Bus-side read controller: wakes the flash with 0xAB, then serves word reads via 0x03.
module spiflash_reader
  import spiflash_pkg::*;
#(
  parameter int unsigned DIV         = 1,
  parameter int unsigned WAKE_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              flash_csb,
  output logic              flash_clk,
  output logic              flash_mosi,
  input  logic              flash_miso,
  output logic              flash_wpn,
  output logic              flash_holdn
);

  state_e            state_q, state_d;
  logic              csb_q, csb_d;
  logic [15:0]       wait_q, wait_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              sh_start;
  logic [63:0]       sh_load;
  logic [6:0]        sh_nbits;
  logic              sh_busy, sh_done;
  logic [DATA_W-1:0] sh_rx;
  logic              accept;

  spi_shifter #(.DIV(DIV)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .start     (sh_start),
    .load_data (sh_load),
    .nbits     (sh_nbits),
    .miso      (flash_miso),
    .busy      (sh_busy),
    .done      (sh_done),
    .sck       (flash_clk),
    .mosi      (flash_mosi),
    .rx_data   (sh_rx)
  );

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d  = state_q;
    csb_d    = csb_q;
    wait_d   = wait_q;
    data_d   = data_q;
    sh_start = 1'b0;
    sh_load  = '0;
    sh_nbits = 7'd64;

    unique case (state_q)
      WAKE_CMD: begin
        if (sh_done) begin
          csb_d   = 1'b1;
          wait_d  = '0;
          state_d = WAKE_WAIT;
        end else if (!sh_busy) begin
          sh_start = 1'b1;
          sh_load  = {CMD_RPD, 56'h0};
          sh_nbits = 7'd8;
          csb_d    = 1'b0;
        end
      end
      WAKE_WAIT: begin
        if (wait_q == 16'(WAKE_CYCLES - 1)) state_d = IDLE;
        else                                wait_d  = wait_q + 16'd1;
      end
      IDLE: begin
        if (accept) begin
          sh_start = 1'b1;
          sh_load  = {CMD_READ, req_addr & 24'hFFFFFC, 32'h0};
          csb_d    = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (sh_done) begin
          csb_d   = 1'b1;
          data_d  = byte_swap(sh_rx);
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = WAKE_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAKE_CMD;
      csb_q   <= 1'b1;
      wait_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      csb_q   <= csb_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
    end
  end

  assign rsp_valid   = (state_q == RESP);
  assign rsp_data    = data_q;
  assign flash_csb   = csb_q;
  assign flash_wpn   = 1'b1;
  assign flash_holdn = 1'b1;

endmodule

// File: tb/tb_spiflash_reader.sv
// Directed bench for spiflash_reader: DIV=1 and DIV=3 instances sharing one behavioural flash.
module tb_spiflash_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       = 1'b1;
  logic        sel       = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [23:0] req_addr  = '0;
  logic        f_miso    = 1'b0;

  logic        req_ready_a, rsp_valid_a, csb_a, sck_a, mosi_a, wpn_a, holdn_a;
  logic [31:0] rsp_data_a;
  logic        req_ready_b, rsp_valid_b, csb_b, sck_b, mosi_b, wpn_b, holdn_b;
  logic [31:0] rsp_data_b;

  spiflash_reader #(.DIV(1), .WAKE_CYCLES(64)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(req_ready_a), .req_addr(req_addr),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready & ~sel), .rsp_data(rsp_data_a),
    .flash_csb(csb_a), .flash_clk(sck_a), .flash_mosi(mosi_a), .flash_miso(f_miso),
    .flash_wpn(wpn_a), .flash_holdn(holdn_a)
  );

  spiflash_reader #(.DIV(3), .WAKE_CYCLES(64)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(req_ready_b), .req_addr(req_addr),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready & sel), .rsp_data(rsp_data_b),
    .flash_csb(csb_b), .flash_clk(sck_b), .flash_mosi(mosi_b), .flash_miso(f_miso),
    .flash_wpn(wpn_b), .flash_holdn(holdn_b)
  );

  logic        f_csb, f_clk, f_mosi, m_req_ready, m_rsp_valid;
  logic [31:0] m_rsp_data;
  assign f_csb       = sel ? csb_b       : csb_a;
  assign f_clk       = sel ? sck_b       : sck_a;
  assign f_mosi      = sel ? mosi_b      : mosi_a;
  assign m_req_ready = sel ? req_ready_b : req_ready_a;
  assign m_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
  assign m_rsp_data  = sel ? rsp_data_b  : rsp_data_a;

  int checks = 0;
  int fails  = 0;

  // Flash contents: the word at 0x100000 is 13 00 00 00, everything else is address-derived.
  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (a[23:2] == 22'h040000) return (a[1:0] == 2'd0) ? 8'h13 : 8'h00;
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  // Flash model: samples mosi on SCK rise, drives read data on SCK fall after 32 bits.
  int          m_bits = 0, last_bits = 0, m_idx;
  logic [31:0] m_shift = '0, last_shift = '0;
  logic [23:0] m_a;
  logic [7:0]  m_b;
  logic        p_csb = 1'b1, p_clk = 1'b0;

  always @(f_csb or f_clk) begin
    if (p_csb !== 1'b0 && f_csb === 1'b0) begin
      m_bits = 0; m_shift = '0;
    end else if (p_csb === 1'b0 && f_csb === 1'b1) begin
      last_bits = m_bits; last_shift = m_shift;
    end else if (f_csb === 1'b0 && p_clk === 1'b0 && f_clk === 1'b1) begin
      if (m_bits < 32) m_shift = {m_shift[30:0], f_mosi};
      m_bits++;
    end else if (f_csb === 1'b0 && p_clk === 1'b1 && f_clk === 1'b0) begin
      if (m_bits >= 32 && m_bits < 64) begin
        m_idx  = m_bits - 32;
        m_a    = m_shift[23:0] + 24'(m_idx / 8);
        m_b    = mem_byte(m_a);
        f_miso = m_b[7 - (m_idx % 8)];
      end
    end
    p_csb = f_csb;
    p_clk = f_clk;
  end

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (m_req_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    ok = (m_req_ready === 1'b1);
  endtask

  // Accept on the next edge, then count clk edges until rsp_valid and clk-high samples on the way.
  task automatic do_read(input logic [23:0] addr, output logic [31:0] data, output int lat, output int hi);
    req_addr = addr; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; lat = 0; hi = 0;
    while (m_rsp_valid !== 1'b1 && lat < 1000) begin
      @(negedge clk); lat++;
      if (f_clk === 1'b1) hi++;
    end
    data = m_rsp_data;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (csb_a !== 1'b1) begin fails++; $display("FAIL reset_csb: got %b want 1", csb_a); end
    checks++; if (sck_a !== 1'b0) begin fails++; $display("FAIL reset_sck: got %b want 0", sck_a); end
    checks++; if (mosi_a !== 1'b0) begin fails++; $display("FAIL reset_mosi: got %b want 0", mosi_a); end
    checks++; if (req_ready_a !== 1'b0) begin fails++; $display("FAIL reset_req_ready: got %b want 0", req_ready_a); end
    checks++; if (rsp_valid_a !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_a); end
    checks++; if (rsp_data_a !== 32'h0) begin fails++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data_a); end
    checks++; if ({wpn_a, holdn_a, wpn_b, holdn_b} !== 4'hF) begin fails++; $display("FAIL reset_wp_hold: got %b want 1111", {wpn_a, holdn_a, wpn_b, holdn_b}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (csb_a !== 1'b0) begin fails++; $display("FAIL wake_csb_fall: got %b want 0", csb_a); end
  endtask

  task automatic test_wake();
    int  n = 0;
    bit  high_ok = 1'b1;
    while (csb_a !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++; if (last_bits !== 8) begin fails++; $display("FAIL wake_bits: got %0d want 8", last_bits); end
    checks++; if (last_shift[7:0] !== 8'hAB) begin fails++; $display("FAIL wake_cmd: got %h want ab", last_shift[7:0]); end
    n = 0;
    while (req_ready_a !== 1'b1 && n < 500) begin
      @(negedge clk); n++;
      if (csb_a !== 1'b1) high_ok = 1'b0;
    end
    checks++; if (n !== 64) begin fails++; $display("FAIL wake_wait: got %0d clk want 64", n); end
    checks++; if (!high_ok) begin fails++; $display("FAIL wake_csb_high: got low want high"); end
  endtask

  task automatic test_read(input string name, input logic [23:0] addr, input logic [31:0] exp_data,
                           input logic [31:0] exp_bus, input int exp_lat, input int exp_hi);
    bit ok; logic [31:0] d; int lat, hi;
    wait_ready(ok);
    checks++; if (!ok) begin fails++; $display("FAIL %s_ready: got 0 want 1", name); end
    do_read(addr, d, lat, hi);
    checks++; if (d !== exp_data) begin fails++; $display("FAIL %s_data: got %h want %h", name, d, exp_data); end
    checks++; if (lat !== exp_lat) begin fails++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat); end
    checks++; if (hi !== exp_hi) begin fails++; $display("FAIL %s_sck_high: got %0d want %0d", name, hi, exp_hi); end
    checks++; if (last_shift !== exp_bus) begin fails++; $display("FAIL %s_bus: got %h want %h", name, last_shift, exp_bus); end
    checks++; if (last_bits !== 64) begin fails++; $display("FAIL %s_bits: got %0d want 64", name, last_bits); end
  endtask

  task automatic test_back_to_back();
    bit ok; int n = 0; int bad = 0;
    wait_ready(ok);
    req_addr = 24'h000000; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    while (rsp_valid_a !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (n !== 130) begin fails++; $display("FAIL hold_latency: got %0d want 130", n); end
    req_addr = 24'h100000; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid_a !== 1'b1 || rsp_data_a !== 32'hA6A7A4A5 || req_ready_a !== 1'b0 || csb_a !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid_a, req_ready_a, csb_a} !== 3'b011) begin fails++; $display("FAIL hold_release: got %b want 011", {rsp_valid_a, req_ready_a, csb_a}); end
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if ({req_ready_a, csb_a} !== 2'b00) begin fails++; $display("FAIL pending_accept: got %b want 00", {req_ready_a, csb_a}); end
    n = 0;
    while (rsp_valid_a !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (rsp_data_a !== 32'h00000013 || n !== 130) begin fails++; $display("FAIL pending_read: got %h/%0d want 00000013/130", rsp_data_a, n); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok; int n = 0; int bad = 0;
    logic [31:0] d; int lat, hi;
    wait_ready(ok);
    req_addr = 24'h000004; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    while (m_bits < 40 && n < 500) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({csb_a, sck_a, rsp_valid_a} !== 3'b100) begin fails++; $display("FAIL midrst_pins: got %b want 100", {csb_a, sck_a, rsp_valid_a}); end
    checks++; if (last_bits !== 40) begin fails++; $display("FAIL midrst_abort_bits: got %0d want 40", last_bits); end
    rst = 1'b0;
    n = 0;
    while (req_ready_a !== 1'b1 && n < 500) begin
      @(negedge clk); n++;
      if (rsp_valid_a !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL midrst_rsp_valid: got %0d cycles high want 0", bad); end
    checks++; if (last_bits !== 8 || last_shift[7:0] !== 8'hAB) begin fails++; $display("FAIL midrst_rewake: got %0d/%h want 8/ab", last_bits, last_shift[7:0]); end
    do_read(24'h000004, d, lat, hi);
    checks++; if (d !== 32'hA2A3A0A1) begin fails++; $display("FAIL midrst_read: got %h want a2a3a0a1", d); end
  endtask

  initial begin
    test_reset();
    test_wake();
    test_read("basic",     24'h100000, 32'h00000013, 32'h03100000, 130, 64);
    test_read("unaligned", 24'h000007, 32'hA2A3A0A1, 32'h03000004, 130, 64);
    test_read("top_word",  24'hFFFFFC, 32'h5A5B5859, 32'h03FFFFFC, 130, 64);
    test_back_to_back();
    test_reset_mid();
    sel = 1'b1;
    test_read("div3",      24'h000000, 32'hA6A7A4A5, 32'h03000000, 386, 192);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spiflash_reader.md
Name: spiflash_reader

Overview:
- Memory-mapped read controller between the SoC bus and the external SPI flash pins (flash_csb, flash_clk, flash_io0..3) of the hardware top.
- Accepts 24-bit byte-address word reads and issues single-IO READ (0x03) transactions.
- Returns 32-bit little-endian words for instruction fetch and data loads.
- After reset, issues Release-Power-Down (0xAB) and waits before accepting requests, so the core boots from flash without firmware help.

Parameters:
- DIV, 1, clk cycles per flash_clk half-period (SCK period = 2*DIV clk); legal 1..255
- WAKE_CYCLES, 64, clk cycles csb stays high after the 0xAB command before the first read (tRES1)

Ports:
- clk  in  1  system clock (16 MHz on the board)
- rst  in  1  reset; synchronous and active-high
- req_valid  in  1  read request
- req_ready  out  1  controller can accept a request this cycle
- req_addr  in  24  byte address; bits [1:0] ignored, forced to 0
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes data
- rsp_data  out  32  {byte3,byte2,byte1,byte0}; byte0 is at the lowest address
- flash_csb  out  1  chip select, active low
- flash_clk  out  1  SPI clock, mode 0 (idle low)
- flash_mosi  out  1  drives flash_io0
- flash_miso  in  1  from flash_io1
- flash_wpn  out  1  constant 1, drives io2
- flash_holdn  out  1  constant 1, drives io3

Behaviour:
- Reset values:
  - flash_csb=1, flash_clk=0, flash_mosi=0
  - req_ready=0, rsp_valid=0, rsp_data=0
  - state=WAKE_CMD
- States: WAKE_CMD, WAKE_WAIT, IDLE, SHIFT, RESP.
- Bit engine:
  - shift register sr[63:0] and a bit counter.
  - Each SCK period is 2*DIV clk.
  - Low half: mosi = sr[63] is updated at the start of the low half.
  - Rising SCK edge: the controller samples miso into sr[0] on the same clk edge that raises flash_clk.
  - Falling SCK edge: sr shifts left by one.
- WAKE_CMD:
  - csb=0, shift 8 bits of 0xAB, then csb=1 and go to WAKE_WAIT.
  - csb falls on the first clk after rst deasserts.
- WAKE_WAIT: count WAKE_CYCLES clk with csb=1, then go to IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready:
    - load sr = {8'h03, addr[23:2], 2'b00, 32'h0}
    - csb=0 on the next clk
    - go to SHIFT
- SHIFT:
  - 64 SCK periods: 8 cmd + 24 addr + 32 data.
  - Data bits are sampled MSB-first per byte and bytes arrive in address order. The received 32 bits {b0,b1,b2,b3} are byte-swapped into rsp_data.
  - After the final falling edge, csb=1 and flash_clk=0; go to RESP.
- RESP:
  - rsp_valid=1 with stable rsp_data until rsp_ready; the transfer completes on the cycle rsp_valid&&rsp_ready, then go to IDLE.
  - req_ready=0 while not in IDLE, so there are no overlapping requests.
- Latency: accept edge to rsp_valid high = 128*DIV + 2 clk (130 for DIV=1).
- flash_clk stays low whenever csb=1. csb stays high for at least 1 clk between transactions (at least 2 clk counting RESP with rsp_ready tied high).
- Simultaneous events: rsp_ready asserted during RESP while req_valid is high is not accepted that cycle; the request is accepted in IDLE on the next cycle.
- Reset mid-transaction: on the next clk edge, csb=1, clk=0, rsp_valid=0, any pending data is discarded, and the wake sequence reruns.
- Address wrap: 0xFFFFFC reads bytes FFFFFC..FFFFFF; no wrap within a word.

Decomposition:
- Shared package spiflash_pkg:
  - CMD_READ=8'h03, CMD_RPD=8'hAB
  - state enum
  - ADDR_W=24, DATA_W=32
- One natural sub-module: spi_shifter. It holds the bit engine with DIV divider, sr, counter, mosi/miso, and a start/done handshake, and is reused for the 8-bit wake and 64-bit read.
- FSM and bus handshake live in spiflash_reader.

Test Plan:
- Reset release → csb falls on the next clk; mosi bits across 8 SCK rising edges = 1,0,1,0,1,0,1,1 (0xAB). Then csb is high for WAKE_CYCLES (64) clk, then req_ready=1.
- Flash model preloaded with 0x00100000: 13 00 00 00 → read 0x100000 gives rsp_data=0x00000013 exactly 130 clk after accept. Observed bus bytes are 03 10 00 00.
- Read 0x000007 (unaligned) → address sent is 0x000004, rsp_data={mem[7],mem[6],mem[5],mem[4]}.
- rsp_ready held low 20 cycles → rsp_valid and rsp_data stable, req_ready=0, csb=1. Raising rsp_ready completes the response; a pending req_valid is accepted the following cycle.
- rst pulsed at SCK period 40 of a read → csb=1 and flash_clk=0 next clk, rsp_valid never asserts, 0xAB wake is reissued, and a subsequent read returns correct data.
- DIV=3, read 0x000000 → SCK period 6 clk, latency 386 clk, data matches the model.
